pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Staged reset release for the LED-panel datapath, driven from the PLL lock.
// Resets drop one stage at a time once lock has been stable; any lock loss re-arms all stages.
//
// state      | meaning
// WAIT_LOCK  | all stages held in reset, waiting for synchronized lock
// STABILIZE  | lock seen, counting LOCK_STABLE_CYCLES consecutive locked cycles
// RELEASE    | releasing one stage every STAGE_GAP cycles, bit 0 first
// RUN        | all stages released, ready asserted until lock is lost
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGES             = 3,
    parameter int STAGE_GAP          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              locked,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [7:0]        lock_loss_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-1:0] rst_q, rst_d, rst_shift;
    logic              ready_q, ready_d;
    logic [7:0]        llc_q, llc_d, llc_inc;
    logic              last_stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_sync = sync_q[SYNC_STAGES-1];

    // Shifting left releases stages strictly in order; the last release empties the register.
    assign rst_shift  = rst_q << 1;
    assign last_stage = (rst_shift == '0);
    assign llc_inc    = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            llc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            llc_q   <= llc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked_sync) state_d = STABILIZE;
            STABILIZE: begin
                if (!locked_sync)            state_d = WAIT_LOCK;
                else if (cnt_q == STAB_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (!locked_sync)                         state_d = WAIT_LOCK;
                else if (cnt_q == GAP_LAST && last_stage) state_d = RUN;
            end
            RUN:     if (!locked_sync) state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        llc_d   = llc_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
            STABILIZE: begin
                rst_d   = '1;
                ready_d = 1'b0;
                if (!locked_sync || cnt_q == STAB_LAST) cnt_d = '0;
                else                                    cnt_d = cnt_q + 1'b1;
            end
            RELEASE: begin
                if (!locked_sync) begin
                    cnt_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    llc_d   = llc_inc;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    rst_d   = rst_shift;
                    ready_d = last_stage;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_sync) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    llc_d   = llc_inc;
                end else begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_out         = rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = llc_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a run-length model of the lock history predicts every output
// each cycle, and fixed scenarios pin specific cycle counts with literal expectations.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int L    = 8;
    localparam int S    = 3;
    localparam int G    = 4;

    logic         clk;
    logic         reset;
    logic         locked;
    logic [S-1:0] rst_out;
    logic         ready;
    logic [7:0]   lock_loss_count;
    logic [1:0]   dut_state;

    int tests  = 0;
    int failed = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(L), .STAGES(S), .STAGE_GAP(G)
    ) dut (
        .clk(clk), .reset(reset), .locked(locked), .rst_out(rst_out),
        .ready(ready), .lock_loss_count(lock_loss_count), .state(dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Model: n = consecutive edges at which the FSM has seen synchronized lock high.
    // n=0 waiting, 1..L stabilizing, then G cycles per released stage, then running.
    bit [SYNC-1:0] sdly = '0;
    int            n    = 0;
    int            lcnt = 0;
    bit            ls;
    int            k_rel, rel, exp_st;
    logic [S-1:0]  all_ones, exp_rst;

    always @(posedge clk) begin
        ls = sdly[SYNC-1];
        if (reset) begin
            sdly = '0;
            n    = 0;
            lcnt = 0;
        end else begin
            sdly = {sdly[SYNC-2:0], locked};
            if (ls) begin
                if (n < 1000000) n = n + 1;
            end else begin
                if (n >= 1 + L) lcnt = (lcnt < 255) ? lcnt + 1 : 255;
                n = 0;
            end
        end
        #1;
        k_rel = n - 1 - L;
        if (n == 0)           exp_st = 0;
        else if (n <= L)      exp_st = 1;
        else if (k_rel < S*G) exp_st = 2;
        else                  exp_st = 3;
        rel = 0;
        if (n >= 1 + L) rel = (k_rel / G > S) ? S : k_rel / G;
        all_ones = '1;
        exp_rst  = all_ones << rel;
        pin("model_state", 32'(dut_state), 32'(exp_st));
        pin("model_rst_out", 32'(rst_out), 32'(exp_rst));
        pin("model_ready", 32'(ready), (exp_st == 3) ? 32'd1 : 32'd0);
        pin("model_lock_loss", 32'(lock_loss_count), 32'(lcnt));
    end

    initial begin
        reset  = 1'b1;
        locked = 1'b0;
        step(3);
        pin("reset_state", 32'(dut_state), 0);
        pin("reset_rst_out", 32'(rst_out), 32'h7);
        pin("reset_ready", 32'(ready), 0);
        pin("reset_llc", 32'(lock_loss_count), 0);

        // Basic bring-up: STABILIZE at edge 3, RELEASE at 11, stages drop at 15/19/23.
        reset  = 1'b0;
        locked = 1'b1;
        step(10);
        pin("stab_state", 32'(dut_state), 1);
        pin("stab_rst", 32'(rst_out), 32'h7);
        step(1);
        pin("release_entry", 32'(dut_state), 2);
        step(3);
        pin("rel_c3_rst", 32'(rst_out), 32'h7);
        step(1);
        pin("rel_c4_rst", 32'(rst_out), 32'h6);
        step(4);
        pin("rel_c8_rst", 32'(rst_out), 32'h4);
        step(3);
        pin("rel_c11_ready", 32'(ready), 0);
        step(1);
        pin("run_rst", 32'(rst_out), 32'h0);
        pin("run_ready", 32'(ready), 1);
        pin("run_state", 32'(dut_state), 3);
        pin("run_llc", 32'(lock_loss_count), 0);

        // Lock loss in RUN: rst_out reasserts on the third edge.
        locked = 1'b0;
        step(2);
        pin("loss_run_e2_state", 32'(dut_state), 3);
        step(1);
        pin("loss_run_state", 32'(dut_state), 0);
        pin("loss_run_rst", 32'(rst_out), 32'h7);
        pin("loss_run_ready", 32'(ready), 0);
        pin("loss_run_llc", 32'(lock_loss_count), 1);

        // One-cycle glitch during STABILIZE (counter = 5): full restart, no count.
        locked = 1'b1;
        step(8);
        pin("glitch_pre_state", 32'(dut_state), 1);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(1);
        pin("glitch_e2_state", 32'(dut_state), 1);
        step(1);
        pin("glitch_e3_state", 32'(dut_state), 0);
        pin("glitch_rst", 32'(rst_out), 32'h7);
        step(1);
        pin("glitch_restab", 32'(dut_state), 1);
        step(7);
        pin("glitch_stab_end", 32'(dut_state), 1);
        step(1);
        pin("glitch_release", 32'(dut_state), 2);
        pin("glitch_llc", 32'(lock_loss_count), 1);

        // Lock loss in RELEASE after first stage dropped.
        step(4);
        pin("rel_loss_pre", 32'(rst_out), 32'h6);
        locked = 1'b0;
        step(2);
        pin("rel_loss_e2", 32'(rst_out), 32'h6);
        step(1);
        pin("rel_loss_rst", 32'(rst_out), 32'h7);
        pin("rel_loss_state", 32'(dut_state), 0);
        pin("rel_loss_llc", 32'(lock_loss_count), 2);

        repeat (3) begin
            locked = 1'b1;
            step(23);
            locked = 1'b0;
            step(3);
        end
        pin("llc_five", 32'(lock_loss_count), 5);

        // Reset pulse in RUN clears everything, then the sequence restarts.
        locked = 1'b1;
        step(23);
        pin("pre_reset_run", 32'(dut_state), 3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        pin("rst_pulse_state", 32'(dut_state), 0);
        pin("rst_pulse_rst", 32'(rst_out), 32'h7);
        pin("rst_pulse_ready", 32'(ready), 0);
        pin("rst_pulse_llc", 32'(lock_loss_count), 0);
        step(2);
        pin("restart_wait", 32'(dut_state), 0);
        step(1);
        pin("restart_stab", 32'(dut_state), 1);
        step(20);
        pin("restart_run", 32'(dut_state), 3);
        pin("restart_ready", 32'(ready), 1);

        // Saturation of the lock-loss counter.
        repeat (260) begin
            locked = 1'b0;
            step(3);
            locked = 1'b1;
            step(23);
        end
        pin("llc_sat", 32'(lock_loss_count), 255);
        locked = 1'b0;
        step(3);
        pin("llc_sat_hold", 32'(lock_loss_count), 255);

        // Randomized lock activity with occasional reset pulses.
        repeat (80) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
            end
            locked = 1'b1;
            step($urandom_range(1, 40));
            locked = 1'b0;
            step($urandom_range(1, 4));
        end

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
